// File: rtl/vrf_read_scheduler.sv
// Round-robin arbiter sharing one VRF read port among NUM_REQ requesters,
// with a fixed-latency tracking pipeline that routes read data back to its source.
module vrf_read_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned VRF_LATENCY = 2,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [5*NUM_REQ-1:0]      req_vs,
    input  logic [8*NUM_REQ-1:0]      req_offset,
    input  logic [3*NUM_REQ-1:0]      req_instructionIndex,
    output logic                      vrf_read_valid,
    input  logic                      vrf_read_ready,
    output logic [4:0]                vrf_read_vs,
    output logic [7:0]                vrf_read_offset,
    output logic [2:0]                vrf_read_instructionIndex,
    input  logic [DATA_WIDTH-1:0]     vrf_read_data,
    input  logic                      flush,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_data,
    output logic [15:0]               conflict_count
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   r_ptr;
    logic               r_pv  [VRF_LATENCY];
    logic [PTR_W-1:0]   r_src [VRF_LATENCY];
    logic [15:0]        r_conflict;

    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_gidx;
    logic [PTR_W-1:0]   w_cand;
    logic               w_any;
    logic               w_fire;

    // Scan ptr+1 .. ptr+NUM_REQ; the first valid requester wins.
    always_comb begin
        w_grant = '0;
        w_gidx  = r_ptr;
        w_cand  = '0;
        w_any   = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = PTR_W'((32'(r_ptr) + k) % NUM_REQ);
            if (!w_any && req_valid[w_cand]) begin
                w_any           = 1'b1;
                w_gidx          = w_cand;
                w_grant[w_cand] = 1'b1;
            end
        end
    end

    assign vrf_read_valid = (|req_valid) & ~flush & ~reset;
    assign req_ready      = w_grant & {NUM_REQ{vrf_read_ready & ~flush & ~reset}};
    assign w_fire         = vrf_read_valid & vrf_read_ready;

    always_comb begin
        vrf_read_vs               = '0;
        vrf_read_offset           = '0;
        vrf_read_instructionIndex = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                vrf_read_vs               = req_vs[5*i +: 5];
                vrf_read_offset           = req_offset[8*i +: 8];
                vrf_read_instructionIndex = req_instructionIndex[3*i +: 3];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr      <= PTR_W'(NUM_REQ - 1);
            r_conflict <= '0;
            for (int unsigned s = 0; s < VRF_LATENCY; s++) begin
                r_pv[s]  <= 1'b0;
                r_src[s] <= '0;
            end
        end else begin
            if (w_fire) begin
                r_ptr <= w_gidx;
            end
            // Fire is already gated by flush, so stage 0 needs no extra masking.
            r_pv[0]  <= w_fire;
            r_src[0] <= w_gidx;
            for (int unsigned s = 1; s < VRF_LATENCY; s++) begin
                r_pv[s]  <= r_pv[s-1] & ~flush;
                r_src[s] <= r_src[s-1];
            end
            if (vrf_read_valid && !vrf_read_ready && r_conflict != 16'hFFFF) begin
                r_conflict <= r_conflict + 16'd1;
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        if (r_pv[VRF_LATENCY-1]) begin
            resp_valid[r_src[VRF_LATENCY-1]] = 1'b1;
        end
    end

    assign resp_data      = vrf_read_data;
    assign conflict_count = r_conflict;

endmodule

// File: tb/tb_vrf_read_scheduler.sv
// Directed bench for vrf_read_scheduler: stimulus vectors push expected responses,
// an independent negedge monitor pops and compares them.
module tb_vrf_read_scheduler;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [5*NR-1:0]   req_vs = '0;
    logic [8*NR-1:0]   req_offset = '0;
    logic [3*NR-1:0]   req_instructionIndex = '0;
    logic              vrf_read_valid;
    logic              vrf_read_ready = 1'b0;
    logic [4:0]        vrf_read_vs;
    logic [7:0]        vrf_read_offset;
    logic [2:0]        vrf_read_instructionIndex;
    logic [DW-1:0]     vrf_read_data;
    logic              flush = 1'b0;
    logic [NR-1:0]     resp_valid;
    logic [DW-1:0]     resp_data;
    logic [15:0]       conflict_count;

    logic [31:0]       cyc = 32'd0;
    logic [31:0]       beef_cyc = 32'hFFFF_FFFF;
    logic              mon_en = 1'b0;
    int                n_checks = 0;
    int                n_errors = 0;

    typedef struct packed {
        logic [NR-1:0] rv;
        logic [31:0]   data;
        logic [31:0]   due;
    } exp_t;

    exp_t sb[$];

    vrf_read_scheduler #(.NUM_REQ(NR), .VRF_LATENCY(2), .DATA_WIDTH(DW)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .req_valid                 (req_valid),
        .req_ready                 (req_ready),
        .req_vs                    (req_vs),
        .req_offset                (req_offset),
        .req_instructionIndex      (req_instructionIndex),
        .vrf_read_valid            (vrf_read_valid),
        .vrf_read_ready            (vrf_read_ready),
        .vrf_read_vs               (vrf_read_vs),
        .vrf_read_offset           (vrf_read_offset),
        .vrf_read_instructionIndex (vrf_read_instructionIndex),
        .vrf_read_data             (vrf_read_data),
        .flush                     (flush),
        .resp_valid                (resp_valid),
        .resp_data                 (resp_data),
        .conflict_count            (conflict_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 32'd1;

    // VRF data is a function of the cycle whose read produced it (cyc-2), except the marked cycle.
    assign vrf_read_data = (cyc == beef_cyc) ? 32'hDEADBEEF : {16'hC0DE, 16'(cyc - 32'd2)};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_valid", 32'(resp_valid), 32'(e.rv));
                chk("resp_data", resp_data, e.data);
            end else begin
                chk("resp_idle", 32'(resp_valid), 32'd0);
            end
        end
    end

    // One cycle: drive inputs, check request side at negedge, update scoreboard, advance.
    task automatic vec(input logic [NR-1:0] v, input logic rdy, input logic fl,
                       input logic rs, input logic [NR-1:0] g);
        logic [NR-1:0] exp_rdy;
        logic          exp_vv;
        logic [4:0]    e_vs;
        logic [7:0]    e_off;
        logic [2:0]    e_ii;
        exp_t          e;
        req_valid      = v;
        vrf_read_ready = rdy;
        flush          = fl;
        reset          = rs;
        @(negedge clock);
        exp_rdy = (rdy && !fl && !rs) ? g : '0;
        exp_vv  = (|v) && !fl && !rs;
        e_vs = '0; e_off = '0; e_ii = '0;
        for (int i = 0; i < int'(NR); i++) begin
            if (g[i]) begin
                e_vs  = 5'(i + 3);
                e_off = 8'(8'h18 + i);
                e_ii  = 3'(i + 1);
            end
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("vrf_read_valid", 32'(vrf_read_valid), 32'(exp_vv));
        chk("vrf_read_vs", 32'(vrf_read_vs), 32'(e_vs));
        chk("vrf_read_offset", 32'(vrf_read_offset), 32'(e_off));
        chk("vrf_read_instr", 32'(vrf_read_instructionIndex), 32'(e_ii));
        if (fl || rs) begin
            while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
        end
        if (exp_rdy != '0) begin
            e.rv   = exp_rdy;
            e.due  = cyc + 32'd2;
            e.data = (cyc + 32'd2 == beef_cyc) ? 32'hDEADBEEF : {16'hC0DE, cyc[15:0]};
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < int'(NR); i++) begin
            req_vs[5*i +: 5]               = 5'(i + 3);
            req_offset[8*i +: 8]           = 8'(8'h18 + i);
            req_instructionIndex[3*i +: 3] = 3'(i + 1);
        end
        repeat (2) @(posedge clock);
        #1;
        // Reset state: everything valid but nothing may be offered or accepted.
        vec(4'b1111, 1'b1, 1'b0, 1'b1, 4'b0001);
        chk("rst_conflict", 32'(conflict_count), 32'd0);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        mon_en = 1'b1;

        // Round robin with all requesters valid (ptr starts at 3).
        vec(4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001);
        vec(4'b1111, 1'b1, 1'b0, 1'b0, 4'b0010);
        vec(4'b1111, 1'b1, 1'b0, 1'b0, 4'b0100);
        vec(4'b1111, 1'b1, 1'b0, 1'b0, 4'b1000);
        vec(4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001);
        vec(4'b1111, 1'b1, 1'b0, 1'b0, 4'b0010);
        repeat (3) vec(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);

        // Requester 2 alone, data 0xDEADBEEF two cycles later.
        beef_cyc = cyc + 32'd2;
        vec(4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100);
        repeat (3) vec(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);

        // Stall with requester 1 valid (ptr=2), then fire.
        repeat (3) vec(4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010);
        chk("conflict_3", 32'(conflict_count), 32'd3);
        vec(4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010);
        // Stalled grant moves only to a higher-priority newcomer (ptr=1: order 2,3,0,1).
        vec(4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010);
        vec(4'b0011, 1'b0, 1'b0, 1'b0, 4'b0001);
        chk("conflict_5", 32'(conflict_count), 32'd5);
        vec(4'b0011, 1'b1, 1'b0, 1'b0, 4'b0001);
        vec(4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010);
        repeat (3) vec(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);

        // Flush one cycle after a fire kills that response and blocks the new request.
        vec(4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100);
        vec(4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000);
        repeat (3) vec(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        // ptr still 2 after the flush, so requester 3 wins next.
        vec(4'b1111, 1'b1, 1'b0, 1'b0, 4'b1000);
        // Flush in the delivery cycle does not kill the response already at the output.
        vec(4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001);
        vec(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        vec(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000);
        repeat (2) vec(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);

        // Reset one cycle after a fire: response dropped, ptr back to 3.
        vec(4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100);
        vec(4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
        vec(4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
        repeat (3) vec(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        vec(4'b1001, 1'b1, 1'b0, 1'b0, 4'b0001);
        repeat (3) vec(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        chk("post_rst_conflict", 32'(conflict_count), 32'd0);

        // Saturation of the conflict counter.
        req_valid      = 4'b0001;
        vrf_read_ready = 1'b0;
        repeat (65534) @(posedge clock);
        @(negedge clock);
        chk("conflict_fffe", 32'(conflict_count), 32'h0000_FFFE);
        @(posedge clock);
        @(negedge clock);
        chk("conflict_ffff", 32'(conflict_count), 32'h0000_FFFF);
        chk("stall_ready", 32'(req_ready), 32'd0);
        repeat (4465) @(posedge clock);
        @(negedge clock);
        chk("conflict_sat", 32'(conflict_count), 32'h0000_FFFF);

        req_valid = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vrf_read_scheduler.md
# vrf_read_scheduler

Round-robin scheduler that shares one VRF read port among `NUM_REQ` lane read requesters. It serializes their requests onto the port and tracks each issued read through the fixed VRF read latency. It routes returning data back to the requester that issued it and counts port-conflict stall cycles. It sits between the lane's read-stage requesters and a single VRF bank read port.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `VRF_LATENCY`, 2: cycles from accepted read to data valid (≥1).
- `DATA_WIDTH`, 32: read data width.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_vs`  in  5*NUM_REQ  vector register index, requester i at bits [5i+4:5i].
- `req_offset`  in  8*NUM_REQ  element-group offset, packed as above.
- `req_instructionIndex`  in  3*NUM_REQ  issuing instruction tag, packed as above.
- `vrf_read_valid`  out  1  read request to VRF.
- `vrf_read_ready`  in  1  VRF accepts this cycle; low on write/bank conflict.
- `vrf_read_vs`  out  5  granted request's `vs`.
- `vrf_read_offset`  out  8  granted request's `offset`.
- `vrf_read_instructionIndex`  out  3  granted request's `instructionIndex`.
- `vrf_read_data`  in  DATA_WIDTH  VRF data, valid exactly VRF_LATENCY cycles after a fire.
- `flush`  in  1  cancel all in-flight reads and block new issue this cycle.
- `resp_valid`  out  NUM_REQ  one-hot read-data valid to the originating requester.
- `resp_data`  out  DATA_WIDTH  read data, shared by all requesters.
- `conflict_count`  out  16  saturating count of stalled request cycles.

## Operation
- Priority pointer `ptr` (log2 NUM_REQ bits) holds the last granted index. Priority order is `ptr+1, ptr+2, …` mod NUM_REQ.
- `grant` is the one-hot of the first valid requester in priority order. It is combinational from `req_valid` and `ptr`.
- `vrf_read_valid = |req_valid & ~flush & ~reset`.
- VRF address fields are muxed from the granted requester. They are zero when there is no grant.
- `req_ready[i] = grant[i] & vrf_read_ready & ~flush & ~reset`.
- Fire = `vrf_read_valid & vrf_read_ready`. On fire, `ptr` ← granted index. Without fire, `ptr` holds.
- A VRF stall does not re-arbitrate unfairly. The grant may change while stalled only if a higher-priority requester raises valid; `ptr` is unchanged.
- Tracking pipeline: VRF_LATENCY stages, each holding {valid, src index}.
  - Stage 0 loads {fire, granted index}.
  - Each stage shifts one per cycle, unconditionally, with no backpressure.
- Response: when the last stage is valid, `resp_valid[src]` = 1 and `resp_data = vrf_read_data`.
  - Otherwise `resp_valid` = 0.
  - `resp_data` is don't-care when `resp_valid` is 0; it is driven as pass-through.
- `flush`: clears every pipeline stage's valid bit on the same edge, and suppresses stage 0 loading that cycle.
  - A response already in the last stage during the flush cycle is still delivered that cycle. Clearing takes effect next cycle.
  - `ptr` is unaffected.
- `conflict_count` increments when `vrf_read_valid & ~vrf_read_ready`. It saturates at 0xFFFF.

## Timing
- Reset values:
  - `ptr` = NUM_REQ-1, so requester 0 has highest priority after reset.
  - All pipeline valids = 0, hence `resp_valid` = 0.
  - `conflict_count` = 0.
  - `req_ready` = 0 and `vrf_read_valid` = 0 while `reset` is high.
- Request path is zero-latency combinational: valid at T with ready at T means fire at T.
- Fire at cycle T → `resp_valid[src]` = 1 at cycle T+VRF_LATENCY, for exactly one cycle.
- Throughput: one read per cycle sustained while `vrf_read_ready` = 1. Up to VRF_LATENCY reads are outstanding.
- Back-to-back fires from different requesters produce back-to-back responses in issue order.
- Reset asserted mid-operation: in-flight reads are dropped, and no `resp_valid` appears afterward from pre-reset fires.
- A single requester continuously valid with all others idle is granted every cycle.

## Test plan
- Reset, then all 4 requesters valid, `vrf_read_ready`=1 → grants in order 0,1,2,3,0…; `resp_valid` one-hot sequence identical, delayed 2 cycles.
- Requester 2 alone issues vs=5, offset=0x1A, `vrf_read_data`=0xDEADBEEF at T+2 → `resp_valid`=4'b0100 at T+2 only, `resp_data`=0xDEADBEEF.
- Hold `vrf_read_ready`=0 for 3 cycles with requester 1 valid → `req_ready`=0, `ptr` unchanged, `conflict_count`=3; fire on 4th cycle.
- Fire at T and T+1, `flush` at T+1 → response at T+2 suppressed, the T+1 request not accepted (`req_ready`=0), no `resp_valid` at T+3.
- Force 70000 stalled cycles → `conflict_count` saturates at 0xFFFF.
- Reset asserted one cycle after a fire → no `resp_valid` ever appears; after reset, requester 0 wins a 0/3 tie.
